// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation scheduler: multiplier command
// codes and the controller state encoding.
package rsa_pkg;

    localparam logic [1:0] MM_PRE  = 2'd0;
    localparam logic [1:0] MM_SQR  = 2'd1;
    localparam logic [1:0] MM_MUL  = 2'd2;
    localparam logic [1:0] MM_POST = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SQR  = 3'd2,
        ST_MUL  = 3'd3,
        ST_POST = 3'd4,
        ST_FIN  = 3'd5
    } state_e;

endpackage

// File: rtl/rsa_msb_find.sv
// Priority encoder: index of the most significant set bit of vec, plus a flag
// for the all-zero vector (idx is 0 in that case).
module rsa_msb_find #(
    parameter int W     = 256,
    parameter int IDX_W = 9
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             zero
);

    // Scan upward so the highest set bit is the last one to write idx.
    always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        zero = ~|vec;
    end

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Square-and-multiply scheduler driving an external Montgomery multiplier.
// Optional build macro RSA_SKIP_LEADING_ZERO_EN starts the scan at the MSB set bit.
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int W      = 256,
    parameter int ADDR_W = 5,
    parameter int IDX_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [7:0]        e_data,
    output logic              mm_start,
    output logic [1:0]        mm_op,
    input  logic              mm_done,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  bit_idx
);

    localparam int NBYTES = W / 8;

    state_e             state_r;
    state_e             state_s;
    logic [W-1:0]       e_r;
    logic               mm_start_r;
    logic               mm_start_s;
    logic [1:0]         mm_op_r;
    logic [1:0]         mm_op_s;
    logic               busy_r;
    logic               busy_s;
    logic               done_r;
    logic               done_s;
    logic [IDX_W-1:0]   bit_idx_r;
    logic [IDX_W-1:0]   bit_idx_s;
    logic [IDX_W-1:0]   start_idx_s;
    logic               skip_all_s;
    logic               cur_bit_s;
    logic               ack_s;

`ifdef RSA_SKIP_LEADING_ZERO_EN
    logic [IDX_W-1:0]   msb_idx_s;
    logic               e_zero_s;

    rsa_msb_find #(
        .W     (W),
        .IDX_W (IDX_W)
    ) u_msb_find (
        .vec  (e_r),
        .idx  (msb_idx_s),
        .zero (e_zero_s)
    );

    assign start_idx_s = msb_idx_s;
    assign skip_all_s  = e_zero_s;
`else
    assign start_idx_s = IDX_W'(W - 1);
    assign skip_all_s  = 1'b0;
`endif

    // A done arriving with the command pulse itself cannot belong to that command.
    assign ack_s     = mm_done & ~mm_start_r;
    assign cur_bit_s = |(e_r & ({{(W-1){1'b0}}, 1'b1} << bit_idx_r));

    // Exponent byte store; writable only while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_r <= {W{1'b0}};
        end else if (e_we && (state_r == ST_IDLE)) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (e_addr == ADDR_W'(i)) begin
                    e_r[i*8 +: 8] <= e_data;
                end
            end
        end
    end

    // Next-state and next-output logic of the scheduler.
    always_comb begin
        state_s    = state_r;
        mm_start_s = 1'b0;
        mm_op_s    = mm_op_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        bit_idx_s  = bit_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_PRE;
                    mm_start_s = 1'b1;
                    mm_op_s    = MM_PRE;
                    busy_s     = 1'b1;
                    bit_idx_s  = start_idx_s;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_PRE: begin
                if (ack_s && skip_all_s) begin
                    state_s    = ST_POST;
                    mm_start_s = 1'b1;
                    mm_op_s    = MM_POST;
                end else if (ack_s) begin
                    state_s    = ST_SQR;
                    mm_start_s = 1'b1;
                    mm_op_s    = MM_SQR;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SQR: begin
                if (!ack_s) begin
                    state_s = state_r;
                end else if (cur_bit_s) begin
                    state_s    = ST_MUL;
                    mm_start_s = 1'b1;
                    mm_op_s    = MM_MUL;
                end else if (bit_idx_r == {IDX_W{1'b0}}) begin
                    state_s    = ST_POST;
                    mm_start_s = 1'b1;
                    mm_op_s    = MM_POST;
                end else begin
                    bit_idx_s  = bit_idx_r - IDX_W'(1);
                    mm_start_s = 1'b1;
                    mm_op_s    = MM_SQR;
                end
            end
            ST_MUL: begin
                if (!ack_s) begin
                    state_s = state_r;
                end else if (bit_idx_r == {IDX_W{1'b0}}) begin
                    state_s    = ST_POST;
                    mm_start_s = 1'b1;
                    mm_op_s    = MM_POST;
                end else begin
                    state_s    = ST_SQR;
                    bit_idx_s  = bit_idx_r - IDX_W'(1);
                    mm_start_s = 1'b1;
                    mm_op_s    = MM_SQR;
                end
            end
            ST_POST: begin
                if (ack_s) begin
                    state_s = ST_FIN;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            mm_start_r <= 1'b0;
            mm_op_r    <= MM_PRE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bit_idx_r  <= {IDX_W{1'b0}};
        end else begin
            state_r    <= state_s;
            mm_start_r <= mm_start_s;
            mm_op_r    <= mm_op_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            bit_idx_r  <= bit_idx_s;
        end
    end

    assign mm_start = mm_start_r;
    assign mm_op    = mm_op_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign bit_idx  = bit_idx_r;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Scoreboard bench for rsa_exp_ctrl: a W=8 and a W=256 instance share one
// multiplier model; expected command sequences are queued at start and popped per mm_start.
module tb_rsa_exp_ctrl;
    import rsa_pkg::*;

`ifdef RSA_SKIP_LEADING_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [1:0] op;
        int         idx;
        bit         chk;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic       e_we;
    logic [4:0] e_addr;
    logic [7:0] e_data;
    logic       mm_done_m;
    logic       mm_done_x;
    logic       mm_done_drv;
    bit         sel;
    int         lat;

    logic       a_mm_start, a_busy, a_done;
    logic [1:0] a_mm_op;
    logic [3:0] a_bit_idx;
    logic       b_mm_start, b_busy, b_done;
    logic [1:0] b_mm_op;
    logic [8:0] b_bit_idx;

    logic       mm_start_m, busy_m, done_m;
    logic [1:0] mm_op_m;
    logic [8:0] bit_idx_m;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   dones = 0;
    int   unexpected = 0;
    int   last_mmdone_cyc = -10;
    int   mm_cnt = 0;
    bit   mul_seen = 1'b0;
    cmd_t exp_q[$];

    assign mm_done_drv = mm_done_m | mm_done_x;

    rsa_exp_ctrl #(.W(8), .ADDR_W(2), .IDX_W(4)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .start    (start & ~sel),
        .e_we     (e_we & ~sel),
        .e_addr   (e_addr[1:0]),
        .e_data   (e_data),
        .mm_start (a_mm_start),
        .mm_op    (a_mm_op),
        .mm_done  (mm_done_drv),
        .busy     (a_busy),
        .done     (a_done),
        .bit_idx  (a_bit_idx)
    );

    rsa_exp_ctrl dut_b (
        .clk      (clk),
        .reset    (reset),
        .start    (start & sel),
        .e_we     (e_we & sel),
        .e_addr   (e_addr),
        .e_data   (e_data),
        .mm_start (b_mm_start),
        .mm_op    (b_mm_op),
        .mm_done  (mm_done_drv),
        .busy     (b_busy),
        .done     (b_done),
        .bit_idx  (b_bit_idx)
    );

    always_comb begin
        mm_start_m = sel ? b_mm_start : a_mm_start;
        mm_op_m    = sel ? b_mm_op : a_mm_op;
        busy_m     = sel ? b_busy : a_busy;
        done_m     = sel ? b_done : a_done;
        bit_idx_m  = sel ? b_bit_idx : {5'b0, a_bit_idx};
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Multiplier model: mm_done pulses lat cycles after each mm_start.
    initial begin
        mm_done_m = 1'b0;
        forever begin
            @(negedge clk);
            mm_done_m = 1'b0;
            if (mm_cnt > 0) begin
                mm_cnt--;
                if (mm_cnt == 0) begin
                    mm_done_m = 1'b1;
                    last_mmdone_cyc = cyc;
                end
            end
            if (mm_start_m) mm_cnt = lat;
        end
    end

    // Output monitor: pops the scoreboard on every command pulse.
    initial begin
        cmd_t c;
        forever begin
            @(negedge clk);
            if (mm_start_m) begin
                pulses++;
                if (mm_op_m == MM_MUL) mul_seen = 1'b1;
                check_eq("busy_at_cmd", 32'(busy_m), 32'd1);
                if (exp_q.size() == 0) begin
                    unexpected++;
                end else begin
                    c = exp_q.pop_front();
                    check_eq("op", 32'(mm_op_m), 32'(c.op));
                    if (c.chk) check_eq("bit_idx", 32'(bit_idx_m), 32'(c.idx));
                end
            end
            if (done_m) begin
                dones++;
                check_eq("done_latency", 32'(cyc), 32'(last_mmdone_cyc + 1));
                check_eq("busy_at_done", 32'(busy_m), 32'd0);
            end
        end
    end

    function automatic int push_model(input bit s, input logic [255:0] ev);
        int   w = s ? 256 : 8;
        int   top = w - 1;
        int   n = 0;
        cmd_t c;
        if (SKIP) begin
            top = -1;
            for (int i = 0; i < w; i++) if (ev[i]) top = i;
        end
        c.op = MM_PRE; c.idx = 0; c.chk = 1'b0;
        exp_q.push_back(c); n++;
        for (int i = top; i >= 0; i--) begin
            c.op = MM_SQR; c.idx = i; c.chk = 1'b1;
            exp_q.push_back(c); n++;
            if (ev[i]) begin
                c.op = MM_MUL;
                exp_q.push_back(c); n++;
            end
        end
        c.op = MM_POST; c.idx = 0; c.chk = 1'b0;
        exp_q.push_back(c); n++;
        return n;
    endfunction

    task automatic write_byte(input logic [4:0] addr, input logic [7:0] data);
        e_we = 1'b1; e_addr = addr; e_data = data;
        @(negedge clk);
        e_we = 1'b0;
    endtask

    task automatic run_exp(input bit s, input logic [255:0] ev, input int lat_i, input bit load,
                           input bit disturb, input int exp_cmds, input string tag);
        int n_exp;
        sel = s; lat = lat_i;
        @(negedge clk);
        if (load) begin
            for (int i = 0; i < (s ? 32 : 1); i++) write_byte(5'(i), ev[i*8 +: 8]);
            if (!s) write_byte(5'd1, 8'hFF);
        end
        n_exp = push_model(s, ev);
        if (exp_cmds >= 0) n_exp = exp_cmds;
        pulses = 0; dones = 0; unexpected = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4000 && dones == 0; c++) begin
            @(negedge clk);
            if (disturb && c == 20) begin
                start = 1'b1; e_we = 1'b1; e_addr = 5'd0; e_data = 8'h00;
            end else if (disturb && c == 21) begin
                start = 1'b0; e_we = 1'b0;
            end
        end
        start = 1'b0; e_we = 1'b0;
        repeat (8) @(negedge clk);
        check_eq({tag, "_cmds"}, 32'(pulses), 32'(n_exp));
        check_eq({tag, "_dones"}, 32'(dones), 32'd1);
        check_eq({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_unexpected"}, 32'(unexpected), 32'd0);
        check_eq({tag, "_idle_busy"}, 32'(busy_m), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int p0;
        reset = 1'b1; start = 1'b0; e_we = 1'b0; e_addr = 5'd0; e_data = 8'd0;
        mm_done_x = 1'b0; sel = 1'b0; lat = 3;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_a_mm_start", 32'(a_mm_start), 32'd0);
        check_eq("rst_a_mm_op", 32'(a_mm_op), 32'd0);
        check_eq("rst_a_busy", 32'(a_busy), 32'd0);
        check_eq("rst_a_done", 32'(a_done), 32'd0);
        check_eq("rst_a_bit_idx", 32'(a_bit_idx), 32'd0);
        check_eq("rst_b_mm_start", 32'(b_mm_start), 32'd0);
        check_eq("rst_b_busy", 32'(b_busy), 32'd0);
        check_eq("rst_b_bit_idx", 32'(b_bit_idx), 32'd0);

        // Exponent cleared by reset: start without loading behaves as e=0.
        run_exp(1'b0, 256'h0, 3, 1'b0, 1'b0, SKIP ? 2 : 10, "e_reset_zero");
        run_exp(1'b0, 256'h05, 3, 1'b1, 1'b0, SKIP ? 7 : 12, "e05");

        // Spurious mm_done while idle must not start anything.
        p0 = pulses;
        mm_done_x = 1'b1;
        @(negedge clk);
        mm_done_x = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("idle_done_cmds", 32'(pulses), 32'(p0));
        check_eq("idle_done_busy", 32'(busy_m), 32'd0);

        run_exp(1'b1, {256{1'b1}}, 1, 1'b1, 1'b1, 514, "ones");
        run_exp(1'b1, {256{1'b1}}, 1, 1'b0, 1'b0, 514, "ones_rerun");
        run_exp(1'b0, 256'h0, 3, 1'b1, 1'b0, SKIP ? 2 : 10, "e00");
        run_exp(1'b1, 256'($urandom()), 2, 1'b1, 1'b0, -1, "rand32");
        run_exp(1'b0, 256'h80, 1, 1'b1, 1'b0, SKIP ? 11 : 11, "e80");

        // Reset while a MUL command is outstanding.
        sel = 1'b0; lat = 3;
        @(negedge clk);
        write_byte(5'd0, 8'h05);
        void'(push_model(1'b0, 256'h05));
        mul_seen = 1'b0; dones = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && !mul_seen; c++) @(negedge clk);
        check_eq("rst_mid_mul_seen", 32'(mul_seen), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_mid_busy", 32'(busy_m), 32'd0);
        check_eq("rst_mid_mm_start", 32'(mm_start_m), 32'd0);
        check_eq("rst_mid_done", 32'(done_m), 32'd0);
        exp_q.delete();
        p0 = pulses;
        repeat (10) @(negedge clk);
        check_eq("rst_mid_no_done", 32'(dones), 32'd0);
        check_eq("rst_mid_no_cmds", 32'(pulses), 32'(p0));
        run_exp(1'b0, 256'h05, 3, 1'b1, 1'b0, SKIP ? 7 : 12, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
